// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file with write-pending scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;
  localparam int MAX_WR     = 16;

  // Highest-numbered set bit of a write-port match vector; 0 when none is set.
  function automatic int hi_match(input logic [MAX_WR-1:0] match);
    int sel;
    sel = 0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (match[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: decode claims set a bit, write-back clears it, flush clears all.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wb_en,
  input  logic [NWR*AW-1:0] wb_idx,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_idx,
  input  logic              flush,
  output logic              claim_ready,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_nxt;
  logic             claim_zero;

  assign claim_zero  = (ZERO_REG != 0) && (claim_idx == '0);
  assign claim_ready = (claim_zero || !busy[claim_idx]) && !flush;

  // Order matters: write-back clears first so a same-cycle accepted claim wins.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++) begin
      if (wb_en[w]) busy_nxt[wb_idx[w*AW +: AW]] = 1'b0;
    end
    if (flush) begin
      busy_nxt = '0;
    end else if (claim_en && claim_ready && !claim_zero) begin
      busy_nxt[claim_idx] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        wb_en,
  input  logic [NWR*AW-1:0]     wb_idx,
  input  logic [NWR*DATA_W-1:0] wb_data,
  input  logic [NRD*AW-1:0]     rd_idx,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_idx,
  output logic                  claim_ready,
  input  logic                  flush
);

  // Claim handshake: claim_en is the request, claim_ready the grant; a claim
  // takes effect at the rising edge only when both are high in the same cycle,
  // and claim_ready never depends on claim_en.

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en       (wb_en),
    .wb_idx      (wb_idx),
    .claim_en    (claim_en),
    .claim_idx   (claim_idx),
    .flush       (flush),
    .claim_ready (claim_ready),
    .busy        (busy)
  );

  // Ports are visited in ascending order so the highest-numbered write lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wb_en[w] && !((ZERO_REG != 0) && (wb_idx[w*AW +: AW] == '0)))
          regs[wb_idx[w*AW +: AW]] <= wb_data[w*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic claim_accept;
  assign claim_accept = claim_en && claim_ready;
`endif

  always_comb begin
    logic [AW-1:0] idx;
    logic          zero;
`ifdef REGFILE_BYPASS_EN
    logic [MAX_WR-1:0] match;
    match = '0;
`endif
    idx     = '0;
    zero    = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NRD; r++) begin
      idx  = rd_idx[r*AW +: AW];
      zero = (ZERO_REG != 0) && (idx == '0);
      rd_data[r*DATA_W +: DATA_W] = zero ? '0 : regs[idx];
      rd_busy[r] = busy[idx];
`ifdef REGFILE_BYPASS_EN
      match = '0;
      for (int w = 0; w < NWR; w++) begin
        match[w] = wb_en[w] && (wb_idx[w*AW +: AW] == idx) && !zero;
      end
      // A forwarded value is no longer pending unless a new producer claims it now.
      if (|match) begin
        rd_data[r*DATA_W +: DATA_W] = wb_data[hi_match(match)*DATA_W +: DATA_W];
        rd_busy[r] = claim_accept && (claim_idx == idx);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters, 2 read / 2 write ports).
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wb_en;
  logic [9:0]  wb_idx;
  logic [63:0] wb_data;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        claim_en;
  logic [4:0]  claim_idx;
  logic        claim_ready;
  logic        flush;

  logic [32:0] exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  int checks;
  int failures;

  regfile_mp_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en       (wb_en),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .claim_en    (claim_en),
    .claim_idx   (claim_idx),
    .claim_ready (claim_ready),
    .flush       (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_idle();
    wb_en = '0; wb_idx = '0; wb_data = '0;
    claim_en = 1'b0; claim_idx = '0; flush = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [4:0] i, input logic [31:0] d);
    wb_en[p] = 1'b1;
    wb_idx[p*5 +: 5] = i;
    wb_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input logic [4:0] i0, input logic [4:0] i1);
    rd_idx = {i1, i0};
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
  endtask

  function automatic logic model_ready();
    return !m_busy[claim_idx] && !flush;
  endfunction

  task automatic step();
    logic rdy;
    rdy = model_ready();
    for (int w = 0; w < 2; w++) begin
      if (wb_en[w]) begin
        if (wb_idx[w*5 +: 5] != 0) m_regs[wb_idx[w*5 +: 5]] = wb_data[w*32 +: 32];
        m_busy[wb_idx[w*5 +: 5]] = 1'b0;
      end
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (claim_en && rdy && claim_idx != 0) begin
      m_busy[claim_idx] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // expected {busy, data} for a read of index i given current inputs and model state
  function automatic logic [32:0] exp_read(input logic [4:0] i);
    logic [32:0] e;
    e = {m_busy[i], (i == 0) ? 32'h0 : m_regs[i]};
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < 2; w++) begin
      if (wb_en[w] && wb_idx[w*5 +: 5] == i && i != 0)
        e = {claim_en && model_ready() && claim_idx == i, wb_data[w*32 +: 32]};
    end
`endif
    return e;
  endfunction

  task automatic test_reset();
    logic [32:0] e;
    set_idle();
    for (int i = 0; i < 32; i += 2) begin
      set_rd(5'(i), 5'(i + 1));
      #1;
      exp_q.push_back(33'h0);
      exp_q.push_back(33'h0);
      e = exp_q.pop_front(); checks++;
      if ({rd_busy[0], rd_data[31:0]} !== e) begin failures++;
        $display("FAIL reset_init idx=%0d got=%h exp=%h", i, {rd_busy[0], rd_data[31:0]}, e); end
      e = exp_q.pop_front(); checks++;
      if ({rd_busy[1], rd_data[63:32]} !== e) begin failures++;
        $display("FAIL reset_init idx=%0d got=%h exp=%h", i + 1, {rd_busy[1], rd_data[63:32]}, e); end
    end
    // populate state, then pull reset mid-cycle
    set_wb(0, 5'd1, 32'hCAFE_0001); set_wb(1, 5'd2, 32'hCAFE_0002);
    claim_en = 1'b1; claim_idx = 5'd3;
    step();
    set_idle(); claim_idx = 5'd3; set_rd(5'd1, 5'd3);
    #1; checks++;
    if (rd_data[31:0] !== 32'hCAFE_0001 || rd_busy[1] !== 1'b1) begin failures++;
      $display("FAIL reset_prewrite got=%h/%b exp=cafe0001/1", rd_data[31:0], rd_busy[1]); end
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    exp_q.push_back(33'h0);
    e = exp_q.pop_front(); checks++;
    if ({rd_busy[0], rd_data[31:0]} !== e) begin failures++;
      $display("FAIL reset_async_x1 got=%h exp=%h", {rd_busy[0], rd_data[31:0]}, e); end
    checks++;
    if (rd_busy[1] !== 1'b0 || claim_ready !== 1'b1) begin failures++;
      $display("FAIL reset_async_x3 got=busy%b ready%b exp=busy0 ready1", rd_busy[1], claim_ready); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_collision();
    set_idle();
    set_wb(0, 5'd5, 32'hAAAA_0000); set_wb(1, 5'd5, 32'h1234_5678);
    step();
    set_idle(); set_rd(5'd5, 5'd5);
    #1;
    exp_q.push_back({1'b0, 32'h1234_5678});
    checks++;
    if ({rd_busy[0], rd_data[31:0]} !== exp_q.pop_front()) begin failures++;
      $display("FAIL collision got=%h exp=%h", rd_data[31:0], 32'h1234_5678); end
  endtask

  task automatic test_zero_reg();
    set_idle();
    set_wb(0, 5'd0, 32'hFFFF_FFFF);
    claim_en = 1'b1; claim_idx = 5'd0; set_rd(5'd0, 5'd0);
    #1; checks++;
    if (claim_ready !== 1'b1) begin failures++;
      $display("FAIL zero_claim_ready got=%b exp=1", claim_ready); end
    checks++;
    if (rd_data[31:0] !== 32'h0) begin failures++;
      $display("FAIL zero_no_bypass got=%h exp=0", rd_data[31:0]); end
    step();
    claim_en = 1'b0; wb_en = '0;
    #1;
    exp_q.push_back(33'h0);
    checks++;
    if ({rd_busy[0], rd_data[31:0]} !== exp_q.pop_front() || claim_ready !== 1'b1) begin failures++;
      $display("FAIL zero_after got=%h busy=%b ready=%b exp=0/0/1", rd_data[31:0], rd_busy[0], claim_ready); end
  endtask

  task automatic test_scoreboard();
    set_idle();
    claim_en = 1'b1; claim_idx = 5'd7;
    step();
    claim_en = 1'b0; set_rd(5'd7, 5'd8);
    #1; checks++;
    if (rd_busy[0] !== 1'b1 || claim_ready !== 1'b0) begin failures++;
      $display("FAIL sb_claim got=busy%b ready%b exp=busy1 ready0", rd_busy[0], claim_ready); end
    set_wb(0, 5'd7, 32'h11);
    step();
    set_idle(); claim_idx = 5'd7;
    #1; checks++;
    if (rd_busy[0] !== 1'b0 || claim_ready !== 1'b1 || rd_data[31:0] !== 32'h11) begin failures++;
      $display("FAIL sb_clear got=busy%b ready%b data=%h exp=0/1/11", rd_busy[0], claim_ready, rd_data[31:0]); end
    set_wb(1, 5'd7, 32'h42); claim_en = 1'b1; claim_idx = 5'd7;
    step();
    set_idle();
    #1;
    exp_q.push_back({1'b1, 32'h42});
    checks++;
    if ({rd_busy[0], rd_data[31:0]} !== exp_q.pop_front()) begin failures++;
      $display("FAIL sb_claim_wins got=%b/%h exp=1/00000042", rd_busy[0], rd_data[31:0]); end
  endtask

  task automatic test_flush();
    set_idle();
    claim_en = 1'b1; claim_idx = 5'd3; step();
    claim_idx = 5'd9; step();
    claim_en = 1'b0; set_rd(5'd3, 5'd9);
    #1; checks++;
    if (rd_busy !== 2'b11) begin failures++;
      $display("FAIL flush_pre got=%b exp=11", rd_busy); end
    flush = 1'b1; claim_en = 1'b1; claim_idx = 5'd4;
    #1; checks++;
    if (claim_ready !== 1'b0) begin failures++;
      $display("FAIL flush_ready got=%b exp=0", claim_ready); end
    step();
    set_idle();
    #1; checks++;
    if (rd_busy !== 2'b00) begin failures++;
      $display("FAIL flush_clear got=%b exp=00", rd_busy); end
    set_rd(5'd4, 5'd7);
    #1; checks++;
    if (rd_busy !== 2'b00 || rd_data[63:32] !== 32'h42) begin failures++;
      $display("FAIL flush_x4 got=%b data=%h exp=00/00000042", rd_busy, rd_data[63:32]); end
  endtask

  task automatic test_bypass();
    set_idle();
    set_wb(0, 5'd10, 32'h0000_0100); step();
    set_idle();
    set_wb(1, 5'd10, 32'hDEAD_BEEF); set_rd(5'd10, 5'd11);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
`else
    exp_q.push_back({1'b0, 32'h0000_0100});
`endif
    checks++;
    if ({rd_busy[0], rd_data[31:0]} !== exp_q.pop_front()) begin failures++;
      $display("FAIL bypass_same got=%b/%h", rd_busy[0], rd_data[31:0]); end
    step();
    set_idle();
    #1; checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL bypass_next got=%h exp=deadbeef", rd_data[31:0]); end
  endtask

  task automatic test_random();
    logic [32:0] e;
    logic [4:0]  r0, r1;
    for (int c = 0; c < 400; c++) begin
      set_idle();
      for (int w = 0; w < 2; w++) begin
        if ($urandom_range(0, 1) == 1) set_wb(w, 5'($urandom_range(0, 15)), $urandom);
      end
      claim_en = ($urandom_range(0, 2) != 0);
      claim_idx = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      r0 = 5'($urandom_range(0, 15)); r1 = 5'($urandom_range(0, 31));
      set_rd(r0, r1);
      exp_q.push_back(exp_read(r0));
      exp_q.push_back(exp_read(r1));
      #1;
      e = exp_q.pop_front(); checks++;
      if ({rd_busy[0], rd_data[31:0]} !== e) begin failures++;
        $display("FAIL rand_rd0 cyc=%0d idx=%0d got=%h exp=%h", c, r0, {rd_busy[0], rd_data[31:0]}, e); end
      e = exp_q.pop_front(); checks++;
      if ({rd_busy[1], rd_data[63:32]} !== e) begin failures++;
        $display("FAIL rand_rd1 cyc=%0d idx=%0d got=%h exp=%h", c, r1, {rd_busy[1], rd_data[63:32]}, e); end
      checks++;
      if (claim_ready !== model_ready()) begin failures++;
        $display("FAIL rand_ready cyc=%0d idx=%0d got=%b exp=%b", c, claim_idx, claim_ready, model_ready()); end
      step();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; rd_idx = '0;
    set_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    test_reset();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
